// File: rtl/ps2_host_rx_pkg.sv
// ----------------------------------------------------------------------------
// | Module   : ps2_host_rx_pkg                                               |
// | Brief    : PS/2 frame constants and receiver FSM state encodings          |
// | Revision : 1.0                                                           |
// ----------------------------------------------------------------------------
`default_nettype none

package ps2_host_rx_pkg;

   localparam int   PS2_DATA_BITS = 8;
   localparam logic PS2_START_BIT = 1'b0;
   localparam logic PS2_STOP_BIT  = 1'b1;

   // Encodings are shared with the PS/2 host transmitter.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

endpackage

`default_nettype wire

// File: rtl/ps2_line_filter.sv
// ----------------------------------------------------------------------------
// | Module   : ps2_line_filter                                               |
// | Brief    : 2-flop synchroniser plus run-length glitch filter, idles high  |
// | Revision : 1.0                                                           |
// ----------------------------------------------------------------------------
`default_nettype none

module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic line_in,
   output logic line_out
);

   localparam int c_cnt_w = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]         r_sync;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_level;

   // Level flips only after FILTER_LEN consecutive synced samples disagree with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync  <= 2'b11;
         r_cnt   <= '0;
         r_level <= 1'b1;
      end else begin
         r_sync <= {r_sync[0], line_in};
         if (r_sync[1] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == c_cnt_w'(FILTER_LEN - 1)) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
         end
      end
   end

   assign line_out = r_level;

endmodule

`default_nettype wire

// File: rtl/ps2_host_rx.sv
// ----------------------------------------------------------------------------
// | Module   : ps2_host_rx                                                   |
// | Brief    : Host-side PS/2 receiver with error reporting and byte FIFO     |
// | Revision : 1.0                                                           |
// ----------------------------------------------------------------------------
`default_nettype none

module ps2_host_rx
   import ps2_host_rx_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 10000,
   parameter int FIFO_AW        = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ps2_clk,
   input  logic               ps2_dat,
   output logic [7:0]         rx_data,
   output logic               rx_valid,
   input  logic               rx_ack,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               busy,
   output logic               parity_err,
   output logic               frame_err,
   output logic               overrun,
   input  logic               err_clear
);

   localparam int c_depth = 2 ** FIFO_AW;
   localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES);
   localparam int c_bit_w = $clog2(PS2_DATA_BITS);

   logic w_clk_f, w_dat_f, r_clk_f_q, w_sample;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk(clk), .reset(reset), .line_in(ps2_clk), .line_out(w_clk_f));
   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
      .clk(clk), .reset(reset), .line_in(ps2_dat), .line_out(w_dat_f));

   assign w_sample = r_clk_f_q & ~w_clk_f;

   ps2_state_t         r_state, w_state_nxt;
   logic [c_bit_w-1:0] r_bitcnt, w_bitcnt_nxt;
   logic [7:0]         r_sh, w_sh_nxt;
   logic               r_par_ok, w_par_ok_nxt;
   logic [c_tmo_w-1:0] r_tmo_cnt;
   logic               w_tmo_hit, w_push, w_par_err, w_frm_err;

   assign w_tmo_hit = (r_tmo_cnt == c_tmo_w'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clk_f_q  <= 1'b1;
         r_state    <= ST_IDLE;
         r_bitcnt   <= '0;
         r_sh       <= '0;
         r_par_ok   <= 1'b0;
         r_tmo_cnt  <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         r_clk_f_q  <= w_clk_f;
         r_state    <= w_state_nxt;
         r_bitcnt   <= w_bitcnt_nxt;
         r_sh       <= w_sh_nxt;
         r_par_ok   <= w_par_ok_nxt;
         parity_err <= w_par_err;
         frame_err  <= w_frm_err;
         if (r_state == ST_IDLE || w_sample || w_tmo_hit)
            r_tmo_cnt <= '0;
         else
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_bitcnt_nxt = r_bitcnt;
      w_sh_nxt     = r_sh;
      w_par_ok_nxt = r_par_ok;
      w_push       = 1'b0;
      w_par_err    = 1'b0;
      w_frm_err    = 1'b0;
      if (w_sample) begin
         case (r_state)
            ST_IDLE: begin
               if (w_dat_f == PS2_START_BIT) begin
                  w_state_nxt  = ST_DATA;
                  w_bitcnt_nxt = '0;
               end
            end
            ST_DATA: begin
               w_sh_nxt     = {w_dat_f, r_sh[7:1]};
               w_bitcnt_nxt = r_bitcnt + c_bit_w'(1);
               if (r_bitcnt == c_bit_w'(PS2_DATA_BITS - 1))
                  w_state_nxt = ST_PARITY;
            end
            ST_PARITY: begin
               w_par_ok_nxt = ^{r_sh, w_dat_f};
               w_state_nxt  = ST_STOP;
            end
            default: begin
               w_push      = (w_dat_f == PS2_STOP_BIT) && r_par_ok;
               w_par_err   = !r_par_ok;
               w_frm_err   = (w_dat_f != PS2_STOP_BIT);
               w_state_nxt = ST_IDLE;
            end
         endcase
      end else if (r_state != ST_IDLE && w_tmo_hit) begin
         // Device stopped clocking mid-frame: drop the partial byte.
         w_frm_err   = 1'b1;
         w_sh_nxt    = '0;
         w_state_nxt = ST_IDLE;
      end
   end

   assign busy = (r_state != ST_IDLE);

   logic [7:0]         r_mem [c_depth];
   logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [FIFO_AW:0]   r_level;
   logic               w_full, w_pop, w_push_ok, w_ovr_set;

   assign w_full    = (r_level == (FIFO_AW + 1)'(c_depth));
   assign w_pop     = rx_ack & rx_valid;
   assign w_push_ok = w_push & (~w_full | w_pop);
   assign w_ovr_set = w_push & w_full & ~w_pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < c_depth; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         overrun  <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= r_sh;
            r_wr_ptr        <= r_wr_ptr + FIFO_AW'(1);
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
         if (w_push_ok && !w_pop)
            r_level <= r_level + (FIFO_AW + 1)'(1);
         else if (!w_push_ok && w_pop)
            r_level <= r_level - (FIFO_AW + 1)'(1);
         // A fresh overrun outranks a simultaneous clear.
         if (w_ovr_set)
            overrun <= 1'b1;
         else if (err_clear)
            overrun <= 1'b0;
      end
   end

   assign rx_valid   = (r_level != '0);
   assign rx_data    = r_mem[r_rd_ptr];
   assign fifo_level = r_level;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_rx.sv
// ----------------------------------------------------------------------------
// | Module   : tb_ps2_host_rx                                                |
// | Brief    : Randomised PS/2 device model against a byte-queue reference    |
// | Revision : 1.0                                                           |
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_host_rx;

   localparam int FILTER_LEN     = 8;
   localparam int TIMEOUT_CYCLES = 400;
   localparam int FIFO_AW        = 2;
   localparam int DEPTH          = 4;
   localparam int HALF           = 40;

   logic               clk = 1'b0;
   logic               reset, ps2_clk, ps2_dat, rx_ack, err_clear;
   logic [7:0]         rx_data;
   logic               rx_valid, busy, parity_err, frame_err, overrun;
   logic [FIFO_AW:0]   fifo_level;

   ps2_host_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .FIFO_AW(FIFO_AW)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack), .fifo_level(fifo_level),
      .busy(busy), .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
      .err_clear(err_clear));

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] q[$];
   logic       model_ovr = 1'b0;
   int         stop_lat = 12;
   logic       valid_at_idle;
   int         level_at_idle;

   int   par_rise = 0, par_hi = 0, frm_rise = 0, frm_hi = 0, busy_hi = 0;
   logic par_q = 1'b0, frm_q = 1'b0;

   always @(negedge clk) begin
      if (parity_err) par_hi <= par_hi + 1;
      if (parity_err && !par_q) par_rise <= par_rise + 1;
      if (frame_err) frm_hi <= frm_hi + 1;
      if (frame_err && !frm_q) frm_rise <= frm_rise + 1;
      if (busy) busy_hi <= busy_hi + 1;
      par_q <= parity_err;
      frm_q <= frame_err;
   end

   task automatic drive_bit(input logic b);
      repeat (HALF / 2) @(negedge clk);
      ps2_dat = b;
      repeat (HALF / 2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   // One device frame; the reference queue is updated from the frame's own bits.
   task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop, input logic ack_at_push);
      logic [10:0] bits;
      int          n;
      logic        done;
      bits = {stop, (~^d) ^ flip, d, 1'b0};
      for (int i = 0; i < 10; i++) drive_bit(bits[i]);
      repeat (HALF / 2) @(negedge clk);
      ps2_dat = bits[10];
      repeat (HALF / 2) @(negedge clk);
      ps2_clk = 1'b0;
      n = 0;
      done = 1'b0;
      while (!done && n < 60) begin
         if (ack_at_push && n == stop_lat - 1) rx_ack = 1'b1;
         @(negedge clk);
         rx_ack = 1'b0;
         n++;
         if (!busy) done = 1'b1;
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL frame_end_wait: busy still %b after %0d cycles, required 0", busy, n);
      end else if (!ack_at_push) begin
         stop_lat = n;
      end
      valid_at_idle = rx_valid;
      level_at_idle = int'(fifo_level);
      if (HALF > n) repeat (HALF - n) @(negedge clk);
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      repeat (HALF) @(negedge clk);
      if (!flip && stop) begin
         if (ack_at_push && q.size() > 0) begin
            void'(q.pop_front());
            q.push_back(d);
         end else if (q.size() < DEPTH) begin
            q.push_back(d);
         end else begin
            model_ovr = 1'b1;
         end
      end
   endtask

   task automatic ack_one();
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      void'(q.pop_front());
   endtask

   task automatic test_reset();
      reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; rx_ack = 1'b0; err_clear = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if ({rx_valid, busy, parity_err, frame_err, overrun} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b, required 00000", {rx_valid, busy, parity_err, frame_err, overrun});
      end
      n_checks++;
      if (rx_data !== 8'h00 || fifo_level !== '0) begin
         n_fail++;
         $display("FAIL reset_data: data %h level %0d, required 00 / 0", rx_data, fifo_level);
      end
   endtask

   task automatic test_single();
      int p0, f0;
      p0 = par_rise; f0 = frm_rise;
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (valid_at_idle !== 1'b1 || level_at_idle != 1) begin
         n_fail++;
         $display("FAIL single_timing: valid %b level %0d when busy fell, required 1 / 1", valid_at_idle, level_at_idle);
      end
      n_checks++;
      if (rx_data !== 8'h1C) begin
         n_fail++;
         $display("FAIL single_data: got %h, required 1c", rx_data);
      end
      n_checks++;
      if (par_rise != p0 || frm_rise != f0) begin
         n_fail++;
         $display("FAIL single_errs: parity %0d frame %0d pulses, required 0 / 0", par_rise - p0, frm_rise - f0);
      end
      ack_one();
      n_checks++;
      if (rx_valid !== 1'b0 || fifo_level !== '0) begin
         n_fail++;
         $display("FAIL single_pop: valid %b level %0d, required 0 / 0", rx_valid, fifo_level);
      end
   endtask

   task automatic test_parity();
      int p0, h0;
      p0 = par_rise; h0 = par_hi;
      send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (par_rise - p0 != 1 || par_hi - h0 != 1) begin
         n_fail++;
         $display("FAIL parity_pulse: %0d pulses %0d cycles, required 1 / 1", par_rise - p0, par_hi - h0);
      end
      n_checks++;
      if (rx_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL parity_state: valid %b busy %b, required 0 / 0", rx_valid, busy);
      end
   endtask

   task automatic test_framing();
      int f0;
      f0 = frm_rise;
      send_frame(8'h55, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (frm_rise - f0 != 1 || fifo_level !== '0) begin
         n_fail++;
         $display("FAIL framing_stop: %0d pulses level %0d, required 1 / 0", frm_rise - f0, fifo_level);
      end
      send_frame(8'h29, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (rx_data !== 8'h29 || fifo_level !== 3'd1) begin
         n_fail++;
         $display("FAIL framing_next: data %h level %0d, required 29 / 1", rx_data, fifo_level);
      end
      ack_one();
   endtask

   task automatic test_timeout();
      int f0, n;
      f0 = frm_rise;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'($urandom_range(0, 1)));
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_busy: got %b mid-frame, required 1", busy);
      end
      n = HALF;
      while (busy && n < TIMEOUT_CYCLES + 200) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (busy !== 1'b0 || n < TIMEOUT_CYCLES || n > TIMEOUT_CYCLES + 30) begin
         n_fail++;
         $display("FAIL timeout_abort: busy %b after %0d cycles, required 0 within %0d..%0d",
                  busy, n, TIMEOUT_CYCLES, TIMEOUT_CYCLES + 30);
      end
      repeat (5) @(negedge clk);
      n_checks++;
      if (frm_rise - f0 != 1 || fifo_level !== '0) begin
         n_fail++;
         $display("FAIL timeout_err: %0d pulses level %0d, required 1 / 0", frm_rise - f0, fifo_level);
      end
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (rx_data !== 8'h5A || fifo_level !== 3'd1) begin
         n_fail++;
         $display("FAIL timeout_next: data %h level %0d, required 5a / 1", rx_data, fifo_level);
      end
      ack_one();
   endtask

   task automatic test_overrun();
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (int'(fifo_level) != q.size() || q.size() != 4 || overrun !== model_ovr) begin
         n_fail++;
         $display("FAIL overrun_full: level %0d ovr %b, required %0d / %b", fifo_level, overrun, q.size(), model_ovr);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rx_data !== q[0]) begin
            n_fail++;
            $display("FAIL overrun_order: got %h, required %h", rx_data, q[0]);
         end
         ack_one();
      end
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      model_ovr = 1'b0;
      n_checks++;
      if (overrun !== 1'b0 || fifo_level !== '0) begin
         n_fail++;
         $display("FAIL overrun_clear: ovr %b level %0d, required 0 / 0", overrun, fifo_level);
      end
      for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b0, 1'b1, 1'b0);
      send_frame(8'hE7, 1'b0, 1'b1, 1'b1);
      n_checks++;
      if (fifo_level !== 3'd4 || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL pushpop_full: level %0d ovr %b, required 4 / 0", fifo_level, overrun);
      end
      while (q.size() > 0) begin
         n_checks++;
         if (rx_data !== q[0]) begin
            n_fail++;
            $display("FAIL pushpop_order: got %h, required %h", rx_data, q[0]);
         end
         ack_one();
      end
   endtask

   task automatic test_random();
      int p0, f0;
      logic [7:0] d;
      logic flip, stop;
      for (int k = 0; k < 8; k++) begin
         d = 8'($urandom);
         flip = ($urandom_range(0, 3) == 0);
         stop = ($urandom_range(0, 3) != 0);
         p0 = par_rise; f0 = frm_rise;
         send_frame(d, flip, stop, 1'b0);
         n_checks++;
         if (par_rise - p0 != int'(flip) || frm_rise - f0 != int'(!stop) ||
             int'(fifo_level) != q.size() || overrun !== model_ovr) begin
            n_fail++;
            $display("FAIL random_frame: d %h par %0d frm %0d lvl %0d ovr %b, required %0d %0d %0d %b",
                     d, par_rise - p0, frm_rise - f0, fifo_level, overrun, flip, !stop, q.size(), model_ovr);
         end
         if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
            n_checks++;
            if (rx_data !== q[0]) begin
               n_fail++;
               $display("FAIL random_head: got %h, required %h", rx_data, q[0]);
            end
            ack_one();
         end
      end
      while (q.size() > 0) begin
         n_checks++;
         if (rx_data !== q[0]) begin
            n_fail++;
            $display("FAIL random_drain: got %h, required %h", rx_data, q[0]);
         end
         ack_one();
      end
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      model_ovr = 1'b0;
   endtask

   task automatic test_glitch_reset();
      int b0;
      b0 = busy_hi;
      ps2_dat = 1'b0;
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (30) @(negedge clk);
      ps2_dat = 1'b1;
      repeat (20) @(negedge clk);
      n_checks++;
      if (busy_hi != b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch: busy for %0d cycles, required 0", busy_hi - b0);
      end
      send_frame(8'h3B, 1'b0, 1'b1, 1'b0);
      drive_bit(1'b0);
      for (int i = 0; i < 5; i++) drive_bit(1'($urandom_range(0, 1)));
      n_checks++;
      if (busy !== 1'b1 || rx_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL prereset: busy %b valid %b, required 1 / 1", busy, rx_valid);
      end
      #3 reset = 1'b1;
      #1;
      n_checks++;
      if ({rx_valid, busy, parity_err, frame_err, overrun} !== 5'b0 || fifo_level !== '0 || rx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL async_reset: flags %b level %0d data %h, required 00000 / 0 / 00",
                  {rx_valid, busy, parity_err, frame_err, overrun}, fifo_level, rx_data);
      end
      q.delete();
      model_ovr = 1'b0;
      ps2_dat = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (HALF) @(negedge clk);
      send_frame(8'h76, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (rx_data !== 8'h76 || fifo_level !== 3'd1) begin
         n_fail++;
         $display("FAIL post_reset: data %h level %0d, required 76 / 1", rx_data, fifo_level);
      end
      ack_one();
   endtask

   initial begin
      test_reset();
      test_single();
      test_parity();
      test_framing();
      test_timeout();
      test_overrun();
      test_random();
      test_glitch_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
